// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the ALU and its UART front end.
//   - ALU opcode encodings (6-bit, MIPS funct style)
//   - state encoding of the alu_uart_if frame FSM
package alu_pkg;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_NOR = 6'b100111;

    localparam int NB_STATE = 3;

    typedef enum logic [NB_STATE-1:0] {
        S_WAIT_A  = 3'd0,
        S_WAIT_B  = 3'd1,
        S_WAIT_OP = 3'd2,
        S_RESULT  = 3'd3,
        S_SEND    = 3'd4,
        S_WAIT_TX = 3'd5
    } if_state_t;

endpackage

// File: rtl/alu.sv
// alu: combinational ALU driven by the operand/opcode registers.
//   i_dato_a, i_dato_b : operands (NB_DATA)
//   i_op               : opcode (NB_OP), encodings in alu_pkg
//   o_result           : result (NB_DATA), 0 for unknown opcodes
module alu
    import alu_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
)(
    input  logic [NB_DATA-1:0] i_dato_a,
    input  logic [NB_DATA-1:0] i_dato_b,
    input  logic [NB_OP-1:0]   i_op,
    output logic [NB_DATA-1:0] o_result
);

    always_comb begin
        o_result = '0;
        case (i_op)
            OP_ADD:  o_result = i_dato_a + i_dato_b;
            OP_SUB:  o_result = i_dato_a - i_dato_b;
            OP_AND:  o_result = i_dato_a & i_dato_b;
            OP_OR:   o_result = i_dato_a | i_dato_b;
            OP_XOR:  o_result = i_dato_a ^ i_dato_b;
            OP_SRA:  o_result = $signed(i_dato_a) >>> i_dato_b;
            OP_SRL:  o_result = i_dato_a >> i_dato_b;
            OP_NOR:  o_result = ~(i_dato_a | i_dato_b);
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/alu_uart_if_timeout.sv
// if_timeout_counter: inter-byte idle counter for alu_uart_if.
// Only compiled when ALU_IF_TIMEOUT_EN is defined.
//   i_clock, i_reset : clock, synchronous active-high reset
//   i_clear          : zero the counter (priority over i_enable)
//   i_enable         : count one idle cycle
//   o_expire         : high while enabled and count == TIMEOUT_CYCLES-1
`ifdef ALU_IF_TIMEOUT_EN
module if_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 1000000
)(
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int NB_CNT = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [NB_CNT-1:0] r_count;

    // Expiry is decoded from the register so the FSM can act in the same cycle.
    assign o_expire = i_enable && (r_count == NB_CNT'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear)
            r_count <= '0;
        else if (i_enable && !o_expire)
            r_count <= r_count + 1'b1;
    end

endmodule
`endif

// File: rtl/alu_uart_if.sv
// alu_uart_if: byte-stream front end for the ALU.
// Receives A, B, OP bytes from the UART RX, drives the ALU operand registers,
// captures the ALU result and hands it to the UART TX (start/done handshake).
// Optional feature macro: ALU_IF_TIMEOUT_EN (abort a partial frame after
// TIMEOUT_CYCLES idle cycles in S_WAIT_B / S_WAIT_OP).
//   i_clock, i_reset        : clock, synchronous active-high reset
//   i_rx_data, i_rx_done    : received byte + one-cycle valid pulse
//   i_result                : combinational ALU result
//   i_tx_done               : one-cycle pulse, TX finished
//   o_dato_a, o_dato_b, o_op: operand / opcode registers to ALU
//   o_tx_data, o_tx_start   : result byte + one-cycle start pulse to TX
//   o_busy                  : result capture / transmit in progress
module alu_uart_if
    import alu_pkg::*;
#(
    parameter int NB_DATA        = 8,
    parameter int NB_OP          = 6,
    parameter int TIMEOUT_CYCLES = 1000000
)(
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_result,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_dato_a,
    output logic [NB_DATA-1:0] o_dato_b,
    output logic [NB_OP-1:0]   o_op,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy
);

    if_state_t r_state;
    logic      w_accept;
    logic      w_expire;

    // A byte is only taken while collecting a frame; otherwise it is dropped.
    assign w_accept = i_rx_done &&
                      (r_state == S_WAIT_A || r_state == S_WAIT_B || r_state == S_WAIT_OP);

    assign o_busy = (r_state == S_RESULT) || (r_state == S_SEND) || (r_state == S_WAIT_TX);

`ifdef ALU_IF_TIMEOUT_EN
    logic w_tmo_en;
    assign w_tmo_en = (r_state == S_WAIT_B) || (r_state == S_WAIT_OP);

    if_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_clear  (w_accept || !w_tmo_en),
        .i_enable (w_tmo_en),
        .o_expire (w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= S_WAIT_A;
            o_dato_a   <= '0;
            o_dato_b   <= '0;
            o_op       <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
        end else begin
            case (r_state)
                S_WAIT_A: begin
                    if (i_rx_done) begin
                        o_dato_a <= i_rx_data;
                        r_state  <= S_WAIT_B;
                    end
                end
                // A byte on the expiry cycle wins over the abort.
                S_WAIT_B: begin
                    if (i_rx_done) begin
                        o_dato_b <= i_rx_data;
                        r_state  <= S_WAIT_OP;
                    end else if (w_expire) begin
                        r_state  <= S_WAIT_A;
                    end
                end
                S_WAIT_OP: begin
                    if (i_rx_done) begin
                        o_op    <= i_rx_data[NB_OP-1:0];
                        r_state <= S_RESULT;
                    end else if (w_expire) begin
                        r_state <= S_WAIT_A;
                    end
                end
                // The ALU has had a full cycle on the new operands by now.
                S_RESULT: begin
                    o_tx_data  <= i_result;
                    o_tx_start <= 1'b1;
                    r_state    <= S_SEND;
                end
                S_SEND: begin
                    o_tx_start <= 1'b0;
                    r_state    <= S_WAIT_TX;
                end
                S_WAIT_TX: begin
                    if (i_tx_done)
                        r_state <= S_WAIT_A;
                end
                default: begin
                    o_tx_start <= 1'b0;
                    r_state    <= S_WAIT_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_uart_if.sv
// tb_alu_uart_if: scoreboard bench for alu_uart_if with the real alu in the loop.
// Stimulus pushes the expected result byte per frame; a monitor pops and
// compares on every o_tx_start. A TX model answers i_tx_done 20 cycles after start.
// Define ALU_IF_TIMEOUT_EN to add the timeout scenarios (TIMEOUT_CYCLES = 50).
module tb_alu_uart_if;

    localparam int NB_DATA = 8;
    localparam int NB_OP   = 6;

    logic               i_clock;
    logic               i_reset;
    logic [NB_DATA-1:0] i_rx_data;
    logic               i_rx_done;
    logic [NB_DATA-1:0] i_result;
    logic               i_tx_done;
    logic [NB_DATA-1:0] o_dato_a;
    logic [NB_DATA-1:0] o_dato_b;
    logic [NB_OP-1:0]   o_op;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_tx_start;
    logic               o_busy;

    alu_uart_if #(
        .NB_DATA        (NB_DATA),
        .NB_OP          (NB_OP),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_rx_data  (i_rx_data),
        .i_rx_done  (i_rx_done),
        .i_result   (i_result),
        .i_tx_done  (i_tx_done),
        .o_dato_a   (o_dato_a),
        .o_dato_b   (o_dato_b),
        .o_op       (o_op),
        .o_tx_data  (o_tx_data),
        .o_tx_start (o_tx_start),
        .o_busy     (o_busy)
    );

    alu #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) u_alu (
        .i_dato_a (o_dato_a),
        .i_dato_b (o_dato_b),
        .i_op     (o_op),
        .o_result (i_result)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    int n_cmp = 0;
    int n_err = 0;
    int n_frames = 0;
    int n_starts = 0;
    logic [NB_DATA-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one pop per start pulse, and start must never last two cycles.
    initial begin
        logic prev_start;
        logic [NB_DATA-1:0] e;
        prev_start = 1'b0;
        forever begin
            @(negedge i_clock);
            if (o_tx_start) begin
                n_starts++;
                if (prev_start) check("tx_start_width", 32'd2, 32'd1);
                if (exp_q.size() == 0) begin
                    check("unexpected_tx_start", {24'd0, o_tx_data}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_data", {24'd0, o_tx_data}, {24'd0, e});
                end
            end
            prev_start = o_tx_start;
        end
    end

    // TX model: done pulse 20 cycles after start; reset abandons it.
    initial begin
        int tx_cnt;
        tx_cnt = 0;
        i_tx_done = 1'b0;
        forever begin
            @(posedge i_clock); #1;
            i_tx_done = 1'b0;
            if (i_reset)
                tx_cnt = 0;
            else if (o_tx_start)
                tx_cnt = 20;
            else if (tx_cnt > 0) begin
                tx_cnt--;
                if (tx_cnt == 0) i_tx_done = 1'b1;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Called at posedge+1; the byte is sampled at the next edge.
    task automatic send_byte(input logic [7:0] b);
        i_rx_data = b;
        i_rx_done = 1'b1;
        @(posedge i_clock); #1;
        i_rx_done = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 100; k++) begin
            if (!o_busy) break;
            @(posedge i_clock); #1;
        end
        if (k == 100) check("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                         input logic [7:0] exp);
        exp_q.push_back(exp);
        n_frames++;
        send_byte(a);
        send_byte(b);
        send_byte(op);
        wait_idle();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dato_a"},   {24'd0, o_dato_a},  32'd0);
        check({tag, "_dato_b"},   {24'd0, o_dato_b},  32'd0);
        check({tag, "_op"},       {26'd0, o_op},      32'd0);
        check({tag, "_tx_data"},  {24'd0, o_tx_data}, 32'd0);
        check({tag, "_tx_start"}, {31'd0, o_tx_start}, 32'd0);
        check({tag, "_busy"},     {31'd0, o_busy},    32'd0);
    endtask

    initial begin
        i_reset   = 1'b1;
        i_rx_data = '0;
        i_rx_done = 1'b0;
        repeat (3) @(posedge i_clock);
        #1;
        check_all_zero("reset");
        i_reset = 1'b0;
        @(posedge i_clock); #1;

        // 1: ADD with latency / pulse-width checks
        exp_q.push_back(8'h0D);
        n_frames++;
        send_byte(8'h0A);
        send_byte(8'h03);
        send_byte(8'h20);
        check("t1_op", {26'd0, o_op}, 32'h20);
        check("t1_start_E0", {31'd0, o_tx_start}, 32'd0);
        @(posedge i_clock); #1;
        check("t1_start_E1", {31'd0, o_tx_start}, 32'd1);
        check("t1_data_E1", {24'd0, o_tx_data}, 32'h0D);
        @(posedge i_clock); #1;
        check("t1_start_E2", {31'd0, o_tx_start}, 32'd0);
        wait_idle();

        // 2: SUB / AND / OR
        frame(8'h0A, 8'h03, 8'h22, 8'h07);
        frame(8'h0A, 8'h03, 8'h24, 8'h02);
        frame(8'h0A, 8'h03, 8'h25, 8'h0B);

        // 3: shifts, and opcode upper bits ignored
        frame(8'hFB, 8'h03, 8'h03, 8'hFF);
        frame(8'hFB, 8'h03, 8'h02, 8'h1F);
        frame(8'hFB, 8'h03, 8'hE0, 8'hFE);
        check("t3_op_masked", {26'd0, o_op}, 32'h20);

        // 4: byte during busy is dropped
        exp_q.push_back(8'h05);
        n_frames++;
        send_byte(8'h04);
        send_byte(8'h01);
        send_byte(8'h20);
        repeat (3) @(posedge i_clock);
        #1;
        check("t4_busy", {31'd0, o_busy}, 32'd1);
        send_byte(8'h55);
        check("t4_drop_a", {24'd0, o_dato_a}, 32'h04);
        check("t4_drop_b", {24'd0, o_dato_b}, 32'h01);
        check("t4_drop_op", {26'd0, o_op}, 32'h20);
        wait_idle();
        frame(8'h0A, 8'h03, 8'h26, 8'h09);

        // 5a: reset while waiting for OP
        send_byte(8'h11);
        send_byte(8'h22);
        i_reset = 1'b1;
        @(posedge i_clock); #1;
        i_reset = 1'b0;
        check_all_zero("t5a");
        send_byte(8'h44);
        check("t5a_reload_a", {24'd0, o_dato_a}, 32'h44);
        check("t5a_b_cleared", {24'd0, o_dato_b}, 32'h00);

        // 5b: reset while waiting for TX done
        exp_q.push_back(8'h45);
        n_frames++;
        send_byte(8'h01);
        send_byte(8'h20);
        repeat (4) @(posedge i_clock);
        #1;
        check("t5b_busy", {31'd0, o_busy}, 32'd1);
        i_reset = 1'b1;
        @(posedge i_clock); #1;
        i_reset = 1'b0;
        check_all_zero("t5b");
        repeat (30) @(posedge i_clock);
        #1;
        check("t5b_idle", {31'd0, o_busy}, 32'd0);

`ifdef ALU_IF_TIMEOUT_EN
        // 6a: idle after A aborts the frame
        frame(8'h0A, 8'h03, 8'h20, 8'h0D);
        send_byte(8'h11);
        repeat (60) @(posedge i_clock);
        #1;
        send_byte(8'h22);
        check("t6a_reload_a", {24'd0, o_dato_a}, 32'h22);
        check("t6a_b_kept", {24'd0, o_dato_b}, 32'h03);
        exp_q.push_back(8'h23);
        n_frames++;
        send_byte(8'h01);
        send_byte(8'h20);
        wait_idle();

        // 6b: B byte lands on the expiry cycle and is accepted
        send_byte(8'h30);
        repeat (49) @(posedge i_clock);
        #1;
        send_byte(8'h02);
        check("t6b_b_accepted", {24'd0, o_dato_b}, 32'h02);
        check("t6b_a_kept", {24'd0, o_dato_a}, 32'h30);
        exp_q.push_back(8'h32);
        n_frames++;
        send_byte(8'h20);
        wait_idle();
`endif

        repeat (5) @(posedge i_clock);
        #1;
        check("start_count", n_starts, n_frames);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
